// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues one memory read at pc, holds the returned
// word for decode, and advances pc to npc when downstream retires it.
module ifetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h00000C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  output logic [29:0] pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // ack is only honoured in REQ and ready only in HOLD, so they never interact.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d         = npc;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a transaction-level model is compared on every
// falling edge, with directed sequences pinning reset, latency and wrap behaviour.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] npc = '0;
  logic [29:0] pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] retire_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .npc(npc), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Transaction model: after reset one dead cycle, then alternate between
  // "waiting for a word" and "holding a word" on the handshakes.
  bit          m_boot = 1'b1;
  bit          m_have = 1'b0;
  logic [29:0] m_pc = 30'hC00;
  logic [31:0] m_instr = '0;
  logic [31:0] m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot <= 1'b1; m_have <= 1'b0; m_pc <= 30'hC00; m_instr <= '0; m_cnt <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_have) begin
      if (imem_ack) begin m_instr <= imem_rdata; m_have <= 1'b1; end
    end else if (instr_ready) begin
      m_pc <= npc; m_cnt <= m_cnt + 1; m_have <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_pc",    {2'b0, pc}, {2'b0, m_pc});
      check("m_addr",  {2'b0, imem_addr}, {2'b0, m_pc});
      check("m_req",   {31'b0, imem_req}, {31'b0, !m_boot && !m_have});
      check("m_valid", {31'b0, instr_valid}, {31'b0, m_have});
      check("m_instr", instr, m_instr);
      check("m_cnt",   retire_cnt, m_cnt);
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] held;

  initial begin
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    check("rst_pc", {2'b0, pc}, 32'h00000C00);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    step; step;
    rst = 1'b0;
    step;
    // first REQ cycle appears one cycle after release
    check("boot_req", {31'b0, imem_req}, 32'd1);
    check("boot_addr", {2'b0, imem_addr}, 32'h00000C00);
    imem_ack = 1'b1; imem_rdata = 32'h3C011234;
    step;
    imem_ack = 1'b0;
    check("first_instr", instr, 32'h3C011234);
    check("first_valid", {31'b0, instr_valid}, 32'd1);
    check("first_pc", {2'b0, pc}, 32'h00000C00);
    check("first_cnt", retire_cnt, 32'd0);
    instr_ready = 1'b1; npc = 30'hC01;
    step;
    instr_ready = 1'b0;
    check("ret_pc", {2'b0, pc}, 32'h00000C01);
    check("ret_addr", {2'b0, imem_addr}, 32'h00000C01);
    check("ret_req", {31'b0, imem_req}, 32'd1);
    check("ret_valid", {31'b0, instr_valid}, 32'd0);
    check("ret_cnt", retire_cnt, 32'd1);
    // delayed ack: request held stable
    for (int i = 0; i < 5; i++) begin
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", {2'b0, imem_addr}, 32'h00000C01);
      check("wait_valid", {31'b0, instr_valid}, 32'd0);
      npc = 30'($urandom);
      step;
    end
    held = $urandom;
    imem_ack = 1'b1; imem_rdata = held;
    step;
    // stall in HOLD with toggling npc and spurious acks
    for (int i = 0; i < 3; i++) begin
      npc = 30'($urandom); imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      step;
      check("stall_pc", {2'b0, pc}, 32'h00000C01);
      check("stall_instr", instr, held);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 30'h0D10;
    step;
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
    step;
    imem_ack = 1'b0;
    check("hold_pc", {2'b0, pc}, 32'h00000D10);
    // asynchronous reset in the middle of a HOLD cycle
    #1 rst = 1'b1;
    #1;
    check("arst_pc", {2'b0, pc}, 32'h00000C00);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_cnt", retire_cnt, 32'd0);
    step; step;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    step;
    check("restart_req", {31'b0, imem_req}, 32'd1);
    check("restart_addr", {2'b0, imem_addr}, 32'h00000C00);
    check("restart_valid", {31'b0, instr_valid}, 32'd0);
    step;
    imem_ack = 1'b0;
    check("restart_instr", instr, 32'h12345678);
    // counter wrap
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    #1 release dut.retire_cnt_q;
    instr_ready = 1'b1; npc = 30'h0C40;
    step;
    instr_ready = 1'b0;
    check("wrap_cnt", retire_cnt, 32'd0);
    check("wrap_pc", {2'b0, pc}, 32'h00000C40);
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 800; i++) begin
      step;
      imem_ack    = ($urandom_range(0, 2) == 0);
      instr_ready = ($urandom_range(0, 2) == 0);
      npc         = 30'($urandom);
      imem_rdata  = $urandom;
      rst         = ($urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    step; step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 30'h00000C00, word address loaded into pc on reset (byte address 0x00003000).
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port npc  input  30 [31:2]  next word address from the next-PC stage.
REQ-005 Port pc  output  30 [31:2]  current word address, fed to the next-PC stage.
REQ-006 Port imem_req  output  1  instruction-memory read request.
REQ-007 Port imem_addr  output  30 [31:2]  read address, equal to pc.
REQ-008 Port imem_ack  input  1  memory has returned data on imem_rdata this cycle.
REQ-009 Port imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-010 Port instr  output  32  held instruction for decode.
REQ-011 Port instr_valid  output  1  instr is valid and belongs to pc.
REQ-012 Port instr_ready  input  1  downstream retires instr this cycle.
REQ-013 Port retire_cnt  output  32  count of retired instructions.

Function
REQ-014 FSM states: IDLE, REQ, HOLD; all outputs are registered or decoded from registered state only.
REQ-015 IDLE: imem_req=0, instr_valid=0; unconditionally -> REQ on the next edge.
REQ-016 REQ: imem_req=1, imem_addr=pc held stable until the ack cycle; imem_ack=0 -> stay in REQ.
REQ-017 REQ with imem_ack=1: instr <= imem_rdata, -> HOLD; imem_req=0 and instr_valid=1 from the next cycle.
REQ-018 HOLD: instr_valid=1, instr and pc held stable; instr_ready=0 -> stay in HOLD.
REQ-019 HOLD with instr_ready=1: pc <= npc (sampled that cycle only), retire_cnt += 1, -> REQ; the new request appears the next cycle.
REQ-020 Minimum per-instruction time: 2 cycles (ack in the first REQ cycle, ready in the first HOLD cycle).
REQ-021 Latency: ack at edge N -> instr_valid=1 after N; ready at edge M -> imem_req=1 with imem_addr=npc(M) after M.
REQ-022 imem_ack outside REQ is ignored: no change to instr, state or pc.
REQ-023 instr_ready outside HOLD is ignored: no pc update and no count.
REQ-024 npc is ignored in every cycle except a HOLD&instr_ready cycle; pc never changes in any other cycle.
REQ-025 retire_cnt wraps 32'hFFFFFFFF -> 0 with no flag.
REQ-026 pc takes npc verbatim with no arithmetic; wrap-around of addresses is the next-PC stage's responsibility.
REQ-027 imem_ack and instr_ready are never both acted on in the same cycle, because they belong to different states.

Reset
REQ-028 rst=1 immediately forces state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retire_cnt=0, regardless of clk.
REQ-029 rst asserted mid-request (REQ) or mid-hold (HOLD) abandons the transaction; a late imem_ack after release is ignored unless the block is in REQ.
REQ-030 After rst is released, the first edge -> REQ, and imem_req=1 with imem_addr=30'hC00 appears one cycle after release.

Verification
REQ-031 Reset release, ack on the first REQ cycle with rdata=32'h3C011234 -> instr=32'h3C011234, instr_valid=1, pc=30'hC00, retire_cnt=0.
REQ-032 HOLD with instr_ready=1 and npc=30'hC01 -> next cycle pc=30'hC01, imem_addr=30'hC01, imem_req=1, instr_valid=0, retire_cnt=1.
REQ-033 Ack delayed 5 cycles -> imem_req stays 1 and imem_addr stays constant for 5 cycles; instr_valid=0 throughout.
REQ-034 instr_ready=0 for 3 HOLD cycles while npc toggles -> pc and instr unchanged; spurious imem_ack with rdata=32'hDEADBEEF leaves instr unchanged.
REQ-035 rst pulse mid-HOLD with pc=30'h0D10, asynchronous to clk -> outputs reach their reset values before the next edge; the fetch restarts at 30'hC00.
REQ-036 Preload retire_cnt to 32'hFFFFFFFF by forcing the register, then retire one instruction -> retire_cnt=0; pc still advances normally.
